// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
//   Multicycle shifter: one bit of shift per clock. It replaces a barrel
//   shifter in the datapath.
//
// Ports
//   clk       in   single clock; all state changes on the rising edge
//   reset     in   synchronous, active-high
//   start     in   request pulse; accepted only while idle
//   op        in   00 SLL, 01 SRL, 10 SRA, 11 ROR
//   data_in   in   operand, captured on an accepted start
//   shamt_in  in   shift amount; only the low SHAMT_BITS bits are used
//   busy      out  high whenever the sequencer is not idle
//   done      out  one-cycle pulse; result is valid then and held afterwards
//   result    out  shifted value
//   dbg_state out  current FSM state (0 idle, 1 shift, 2 done)
//
// Handshake: a request is taken on a rising edge where start=1 and busy=0.
// Inputs are don't-care at every other edge. Completion is signalled by a
// single-cycle done, which is decoded from state only.
// ---------------------------------------------------------------------------
module shift_sequencer #(
    parameter int WIDTH      = 32,
    parameter int SHAMT_BITS = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [31:0]      shamt_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [SHAMT_BITS-1:0] r_count;
    logic [1:0]            r_op;
    logic [WIDTH-1:0]      r_result;
    logic [WIDTH-1:0]      w_shifted;
    logic [SHAMT_BITS-1:0] w_shamt;

    // The upper bits of the amount are discarded, so 32 acts as 0 and 33 as 1.
    assign w_shamt = shamt_in[SHAMT_BITS-1:0];

    // Single-bit step for the captured operation.
    always_comb begin
        w_shifted = r_result;
        case (r_op)
            2'b00:   w_shifted = {r_result[WIDTH-2:0], 1'b0};
            2'b01:   w_shifted = {1'b0, r_result[WIDTH-1:1]};
            2'b10:   w_shifted = {r_result[WIDTH-1], r_result[WIDTH-1:1]};
            default: w_shifted = {r_result[0], r_result[WIDTH-1:1]};
        endcase
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    // A zero amount skips straight to DONE.
                    w_next_state = (w_shamt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // The last shift happens on the edge where count is still 1.
                if (r_count == SHAMT_BITS'(1)) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_op     <= 2'b00;
            r_result <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_result <= data_in;
                        r_count  <= w_shamt;
                        r_op     <= op;
                    end
                end
                ST_SHIFT: begin
                    r_result <= w_shifted;
                    r_count  <= r_count - SHAMT_BITS'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign result    = r_result;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data_in;
  logic [31:0] shamt_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  shift_sequencer #(.WIDTH(32), .SHAMT_BITS(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .data_in   (data_in),
    .shamt_in  (shamt_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Shifting by k positions in one go, straight from the operation definitions.
  function automatic logic [31:0] shift_by(input logic [31:0] d, input logic [1:0] o, input int k);
    logic [31:0] r;
    case (o)
      2'b00:   r = d << k;
      2'b01:   r = d >> k;
      2'b10:   r = 32'($signed(d) >>> k);
      default: r = (k == 0) ? d : ((d >> k) | (d << (32 - k)));
    endcase
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  // Phase: 0 idle, 1 shifting, 2 done. Intermediate result after k shifts is
  // the operand shifted by k in one step.
  int          m_phase;
  int          m_n;
  int          m_k;
  logic [31:0] m_d;
  logic [1:0]  m_op;
  logic [31:0] m_res;
  bit          m_valid = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase <= 0;
      m_res   <= 32'h0;
      m_valid <= 1'b1;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_d     <= data_in;
          m_op    <= op;
          m_n     <= int'(shamt_in % 32);
          m_k     <= 0;
          m_res   <= data_in;
          m_phase <= ((shamt_in % 32) == 0) ? 2 : 1;
        end
        1: begin
          m_k   <= m_k + 1;
          m_res <= shift_by(m_d, m_op, m_k + 1);
          if (m_k + 1 == m_n) m_phase <= 2;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  // Compare process: outputs checked every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy",   {31'b0, busy},   {31'b0, m_phase != 0});
      chk("done",   {31'b0, done},   {31'b0, m_phase == 2});
      chk("result", result, m_res);
    end
  end

  // ---------------- driver tasks ----------------
  // Issues one request from idle, optionally jamming random inputs while busy,
  // and returns the result seen with done plus the edge index (E0 = 0) after
  // which done first appeared.
  task automatic do_req(input logic [1:0] o, input logic [31:0] d, input logic [31:0] sh,
                        input bit noise, output logic [31:0] res, output int edge_idx);
    start    = 1'b1;
    op       = o;
    data_in  = d;
    shamt_in = sh;
    @(posedge clk); #1;
    start    = 1'b0;
    edge_idx = 0;
    while (done !== 1'b1 && edge_idx < 40) begin
      if (noise) begin
        start    = 1'($urandom_range(0, 1));
        op       = 2'($urandom_range(0, 3));
        data_in  = $urandom;
        shamt_in = $urandom;
      end
      @(posedge clk); #1;
      edge_idx++;
    end
    start = 1'b0;
    if (edge_idx >= 40) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: no done within 40 edges (op %0d shamt %0d)", o, sh);
    end
    res = result;
    @(posedge clk); #1;
    chk("done_width", {31'b0, done}, 32'h0);
    chk("idle_after", {31'b0, busy}, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] r_res;
  int          r_edge;
  int          pulses;

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    op       = 2'b00;
    data_in  = 32'h0;
    shamt_in = 32'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_busy",   {31'b0, busy}, 32'h0);
    chk("rst_done",   {31'b0, done}, 32'h0);
    chk("rst_result", result, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed cases with literal expectations.
    do_req(2'b00, 32'h0000_0001, 32'd1, 0, r_res, r_edge);
    chk("sll1_res",  r_res, 32'h0000_0002);
    chk("sll1_edge", r_edge, 32'd1);
    chk("sll1_hold", result, 32'h0000_0002);

    do_req(2'b01, 32'h8000_0000, 32'd3, 0, r_res, r_edge);
    chk("srl3_res",  r_res, 32'h1000_0000);
    chk("srl3_edge", r_edge, 32'd3);

    do_req(2'b10, 32'h8000_0000, 32'd2, 0, r_res, r_edge);
    chk("sra2_res",  r_res, 32'hE000_0000);

    do_req(2'b11, 32'h0000_0001, 32'd1, 0, r_res, r_edge);
    chk("ror1_res",  r_res, 32'h8000_0000);

    do_req(2'($urandom_range(0, 3)), 32'hDEAD_BEEF, 32'd0, 0, r_res, r_edge);
    chk("sh0_res",  r_res, 32'hDEAD_BEEF);
    chk("sh0_edge", r_edge, 32'd0);

    do_req(2'($urandom_range(0, 3)), 32'hDEAD_BEEF, 32'd32, 0, r_res, r_edge);
    chk("sh32_res",  r_res, 32'hDEAD_BEEF);
    chk("sh32_edge", r_edge, 32'd0);

    // Requests while busy must be ignored.
    do_req(2'b00, 32'h0000_0001, 32'd3, 1, r_res, r_edge);
    chk("ignore_res",  r_res, 32'h0000_0008);
    chk("ignore_edge", r_edge, 32'd3);

    // start held high: SLL 1 by 2 re-accepted every 4 cycles.
    start    = 1'b1;
    op       = 2'b00;
    data_in  = 32'h0000_0001;
    shamt_in = 32'd2;
    pulses   = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    start = 1'b0;
    chk("held_pulses", pulses, 32'd3);
    @(posedge clk); #1;

    // Reset in the middle of a 3-bit shift.
    start    = 1'b1;
    op       = 2'b00;
    data_in  = 32'h0000_0001;
    shamt_in = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_busy",   {31'b0, busy}, 32'h0);
    chk("midrst_result", result, 32'h0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) pulses++;
      @(posedge clk); #1;
    end
    chk("midrst_nodone", pulses, 32'd0);

    do_req(2'b10, 32'hF000_0000, 32'd1, 0, r_res, r_edge);
    chk("sra_after_rst", r_res, 32'hF800_0000);

    // Sweep: all ops, all amounts, random operand and random upper amount bits.
    for (int o = 0; o < 4; o++) begin
      for (int s = 0; s < 32; s++) begin
        logic [31:0] d;
        logic [31:0] sh;
        d  = $urandom;
        sh = (32'($urandom_range(0, 1023)) << 5) | 32'(s);
        do_req(2'(o), d, sh, 1'($urandom_range(0, 1)), r_res, r_edge);
        chk("sweep_res",  r_res, shift_by(d, 2'(o), s));
        chk("sweep_edge", r_edge, 32'(s));
      end
    end

    @(posedge clk); #1;
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1);
  end

endmodule
